// File: rtl/keypoint_collector.sv
`default_nettype none
// ============================================================================
// Module   : keypoint_collector
// Purpose  : Consumer end of the NMS keypoint stream. Keypoints that arrive
//            between frame_start and frame_end are buffered in a FWFT FIFO.
//            They are drained over a valid/ready stream. Every frame is
//            closed with one trailer beat that carries the kept and dropped
//            keypoint counts.
// Ports    : clk, rst (async, active-high)
//            frame_start / frame_end : 1-cycle frame delimiters
//            kp_valid, kp_score, kp_x, kp_y : keypoint strobe (no backpressure)
//            out_valid, out_ready, out_data, out_trailer : output stream
//              keypoint beat : {x, y, score}
//              trailer beat  : {zero-pad, drop_cnt, kept_cnt}
//            busy        : a frame is in progress (not idle)
//            err_overlap : sticky, frame_start seen while a frame was open
// Revision : 1.0 - initial release
// ============================================================================
module keypoint_collector #(
  parameter int SCORE_WIDTH      = 8,
  parameter int IMAGE_WIDTH      = 640,
  parameter int IMAGE_HEIGHT     = 480,
  parameter int FIFO_DEPTH       = 64,
  parameter int MAX_KP_PER_FRAME = 500,
  localparam int X_W = $clog2(IMAGE_WIDTH),
  localparam int Y_W = $clog2(IMAGE_HEIGHT),
  localparam int W   = X_W + Y_W + SCORE_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic                   frame_end,
  input  logic                   kp_valid,
  input  logic [SCORE_WIDTH-1:0] kp_score,
  input  logic [X_W-1:0]         kp_x,
  input  logic [Y_W-1:0]         kp_y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_data,
  output logic                   out_trailer,
  output logic                   busy,
  output logic                   err_overlap
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(MAX_KP_PER_FRAME + 1);

  localparam logic [CNT_W-1:0] c_max_kp  = CNT_W'(MAX_KP_PER_FRAME);
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   c_ptr_one = {{PTR_W{1'b0}}, 1'b1};

  // Both counts must fit side by side in one output beat.
  if (2 * CNT_W > W) begin : g_bad_width
    $error("keypoint_collector: trailer counts do not fit in out_data");
  end

  if (FIFO_DEPTH < 2 || (1 << PTR_W) != FIFO_DEPTH) begin : g_bad_depth
    $error("keypoint_collector: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2,
    S_TRAILER = 2'd3
  } state_t;

  state_t           state_q,  state_d;
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] kept_q,   kept_d;
  logic [CNT_W-1:0] drop_q,   drop_d;
  logic             err_q,    err_d;

  logic [W-1:0] mem [FIFO_DEPTH];

  logic fifo_empty;
  logic fifo_full;
  logic streaming;
  logic push;
  logic pop;

  // Extra pointer MSB tells a full FIFO apart from an empty one.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  // Keypoint beats are only offered while a frame is being collected or drained.
  assign streaming = (state_q == S_COLLECT) || (state_q == S_DRAIN);

  // Push decision uses the pre-pop fullness: a same-cycle pop does not make room.
  assign push = (state_q == S_COLLECT) && kp_valid && !fifo_full && (kept_q < c_max_kp);
  assign pop  = streaming && !fifo_empty && out_ready;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    kept_d   = kept_q;
    drop_d   = drop_q;
    err_d    = err_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + c_ptr_one;
      kept_d   = kept_q + c_cnt_one;
    end else if ((state_q == S_COLLECT) && kp_valid && (drop_q != {CNT_W{1'b1}})) begin
      drop_d = drop_q + c_cnt_one;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + c_ptr_one;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d = S_COLLECT;
          kept_d  = '0;
          drop_d  = '0;
        end
      end
      S_COLLECT: begin
        // A keypoint arriving with frame_end is still counted above.
        if (frame_end) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Counts are frozen here; the trailer waits until the last kept beat left.
        if (fifo_empty) state_d = S_TRAILER;
      end
      S_TRAILER: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_start && (state_q != S_IDLE)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      kept_q   <= '0;
      drop_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      kept_q   <= kept_d;
      drop_q   <= drop_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: entries are only visible between push and pop.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[PTR_W-1:0]] <= {kp_x, kp_y, kp_score};
    end
  end

  always_comb begin
    out_data = '0;
    if (state_q == S_TRAILER) begin
      out_data[CNT_W-1:0]       = kept_q;
      out_data[2*CNT_W-1:CNT_W] = drop_q;
    end else if (streaming && !fifo_empty) begin
      out_data = mem[rd_ptr_q[PTR_W-1:0]];
    end
  end

  assign out_valid   = (streaming && !fifo_empty) || (state_q == S_TRAILER);
  assign out_trailer = (state_q == S_TRAILER);
  assign busy        = (state_q != S_IDLE);
  assign err_overlap = err_q;

endmodule
`default_nettype wire

// File: tb/tb_keypoint_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypoint_collector
// Purpose  : Self-checking bench for keypoint_collector. Two instances share
//            one stimulus stream: u0 uses the default parameters and u1 uses
//            FIFO_DEPTH=8 / MAX_KP_PER_FRAME=4. A queue-based frame model per
//            instance predicts every beat. Directed frames pin the model with
//            hand-computed trailer values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypoint_collector;

  localparam int W = 27;  // 10 + 9 + 8

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic       frame_end;
  logic       kp_valid;
  logic [7:0] kp_score;
  logic [9:0] kp_x;
  logic [8:0] kp_y;
  logic       out_ready;

  logic [1:0]   ov;
  logic [1:0]   ot;
  logic [1:0]   bz;
  logic [1:0]   eo;
  logic [W-1:0] od0;
  logic [W-1:0] od1;

  logic [1:0]   idle_v;
  logic [W-1:0] trl_w   [2];
  logic [W-1:0] first_w [2];
  int           beats_w [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  keypoint_collector u0 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
    .kp_valid(kp_valid), .kp_score(kp_score), .kp_x(kp_x), .kp_y(kp_y),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od0),
    .out_trailer(ot[0]), .busy(bz[0]), .err_overlap(eo[0])
  );

  keypoint_collector #(.FIFO_DEPTH(8), .MAX_KP_PER_FRAME(4)) u1 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
    .kp_valid(kp_valid), .kp_score(kp_score), .kp_x(kp_x), .kp_y(kp_y),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od1),
    .out_trailer(ot[1]), .busy(bz[1]), .err_overlap(eo[1])
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Frame model: a queue of kept keypoints plus a frame phase
  // (0 no frame, 1 collecting, 2 closed and waiting for its trailer).
  for (genvar gi = 0; gi < 2; gi++) begin : g_model
    localparam int CW   = (gi == 0) ? 9   : 3;
    localparam int MAXK = (gi == 0) ? 500 : 4;
    localparam int DEP  = (gi == 0) ? 64  : 8;

    logic [W-1:0] kq [$];
    int           phase;
    int           kept;
    int           drop;
    int           beats;
    int           ph;
    int           occ;
    bit           hs;
    bit           err;
    logic [W-1:0] trl;
    logic [W-1:0] last_trl;
    logic [W-1:0] first;
    logic         ovi;
    logic         oti;
    logic         bzi;
    logic         eoi;
    logic [W-1:0] odi;

    assign ovi = ov[gi];
    assign oti = ot[gi];
    assign bzi = bz[gi];
    assign eoi = eo[gi];
    assign odi = (gi == 0) ? od0 : od1;

    assign idle_v[gi]  = (phase == 0);
    assign trl_w[gi]   = last_trl;
    assign first_w[gi] = first;
    assign beats_w[gi] = beats;

    initial begin
      phase = 0; kept = 0; drop = 0; beats = 0; err = 1'b0;
      trl = '0; last_trl = '0; first = '0;
    end

    always @(negedge clk) begin
      if (rst) begin
        kq.delete();
        phase = 0; kept = 0; drop = 0; err = 1'b0;
        chk($sformatf("u%0d rst out_valid", gi), 64'(ovi), 64'd0);
        chk($sformatf("u%0d rst out_data", gi), 64'(odi), 64'd0);
        chk($sformatf("u%0d rst out_trailer", gi), 64'(oti), 64'd0);
        chk($sformatf("u%0d rst busy", gi), 64'(bzi), 64'd0);
        chk($sformatf("u%0d rst err_overlap", gi), 64'(eoi), 64'd0);
      end else begin
        chk($sformatf("u%0d busy", gi), 64'(bzi), 64'(phase != 0));
        chk($sformatf("u%0d err_overlap", gi), 64'(eoi), 64'(err));
        if (kq.size() > 0) begin
          chk($sformatf("u%0d kp out_valid", gi), 64'(ovi), 64'd1);
          chk($sformatf("u%0d kp out_trailer", gi), 64'(oti), 64'd0);
          chk($sformatf("u%0d kp out_data", gi), 64'(odi), 64'(kq[0]));
        end else if (ovi) begin
          if (phase == 2) begin
            chk($sformatf("u%0d trailer flag", gi), 64'(oti), 64'd1);
            chk($sformatf("u%0d trailer data", gi), 64'(odi), 64'(trl));
          end else begin
            chk($sformatf("u%0d unexpected beat", gi), 64'(ovi), 64'd0);
          end
        end
      end
    end

    always @(posedge clk) begin
      if (!rst) begin
        ph  = phase;
        occ = kq.size();
        hs  = ovi && out_ready;
        if (hs && occ > 0) begin
          if (beats == 0) first = odi;
          beats++;
          void'(kq.pop_front());
        end else if (hs && ph == 2) begin
          last_trl = odi;
          phase    = 0;
        end
        if (frame_start) begin
          if (ph == 0) begin
            phase = 1; kept = 0; drop = 0; beats = 0;
          end else begin
            err = 1'b1;
          end
        end
        if (ph == 1 && kp_valid) begin
          if (occ < DEP && kept < MAXK) begin
            kq.push_back({kp_x, kp_y, kp_score});
            kept++;
          end else if (drop < (1 << CW) - 1) begin
            drop++;
          end
        end
        if (ph == 1 && frame_end) begin
          phase = 2;
          trl   = W'(kept) | (W'(drop) << CW);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_kp(input int x, input int y, input int s, input bit with_end);
    kp_valid  = 1'b1;
    kp_x      = 10'(x);
    kp_y      = 9'(y);
    kp_score  = 8'(s);
    frame_end = with_end;
    cyc();
    kp_valid  = 1'b0;
    frame_end = 1'b0;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
  endtask

  task automatic end_frame();
    frame_end = 1'b1;
    cyc();
    frame_end = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (idle_v != 2'b11 && k < 3000) begin
      cyc();
      k++;
    end
    if (idle_v != 2'b11) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: frame still open after %0d cycles, expected idle", nm, k);
    end
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; frame_start = 1'b0; frame_end = 1'b0; kp_valid = 1'b0;
    kp_score = '0; kp_x = '0; kp_y = '0; out_ready = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();

    // 1: three keypoints, always ready
    out_ready = 1'b1;
    start_frame();
    send_kp(5, 7, 20, 1'b0);
    send_kp(9, 7, 30, 1'b0);
    send_kp(100, 50, 9, 1'b0);
    end_frame();
    wait_idle("t1 drain");
    chk("t1 u0 first beat", 64'(first_w[0]), 64'({10'd5, 9'd7, 8'd20}));
    chk("t1 u0 beats", 64'(beats_w[0]), 64'd3);
    chk("t1 u0 trailer", 64'(trl_w[0]), 64'd3);
    chk("t1 u1 trailer", 64'(trl_w[1]), 64'd3);

    // 2: 70 keypoints against a stalled sink
    out_ready = 1'b0;
    start_frame();
    for (int i = 0; i < 70; i++) send_kp(i, i, i, 1'b0);
    end_frame();
    repeat (3) cyc();
    out_ready = 1'b1;
    wait_idle("t2 drain");
    chk("t2 u0 beats", 64'(beats_w[0]), 64'd64);
    chk("t2 u0 trailer", 64'(trl_w[0]), 64'd3136);   // drop 6, kept 64
    chk("t2 u1 beats", 64'(beats_w[1]), 64'd4);
    chk("t2 u1 trailer", 64'(trl_w[1]), 64'd60);     // drop saturated 7, kept 4

    // 3: six keypoints, keep cap on u1
    start_frame();
    for (int i = 0; i < 6; i++) send_kp(i + 1, 2 * i, 40 + i, 1'b0);
    end_frame();
    wait_idle("t3 drain");
    chk("t3 u1 beats", 64'(beats_w[1]), 64'd4);
    chk("t3 u1 trailer", 64'(trl_w[1]), 64'd20);     // drop 2, kept 4
    chk("t3 u0 trailer", 64'(trl_w[0]), 64'd6);

    // 4: keypoint together with frame_end
    start_frame();
    send_kp(1, 2, 3, 1'b1);
    wait_idle("t4 drain");
    chk("t4 u0 beats", 64'(beats_w[0]), 64'd1);
    chk("t4 u0 first beat", 64'(first_w[0]), 64'({10'd1, 9'd2, 8'd3}));
    chk("t4 u0 trailer", 64'(trl_w[0]), 64'd1);
    chk("t4 u1 trailer", 64'(trl_w[1]), 64'd1);

    // 5: reset mid-frame with a loaded FIFO
    out_ready = 1'b0;
    start_frame();
    for (int i = 0; i < 10; i++) send_kp(i, 3, 77, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t5 u0 out_valid after rst", 64'(ov[0]), 64'd0);
    chk("t5 u0 busy after rst", 64'(bz[0]), 64'd0);
    cyc();
    out_ready = 1'b1;
    start_frame();
    send_kp(11, 12, 13, 1'b0);
    send_kp(14, 15, 16, 1'b0);
    end_frame();
    wait_idle("t5 drain");
    chk("t5 u0 trailer", 64'(trl_w[0]), 64'd2);
    chk("t5 u1 trailer", 64'(trl_w[1]), 64'd2);

    // 6: frame_start while draining, then keypoints while idle
    out_ready = 1'b0;
    start_frame();
    for (int i = 0; i < 5; i++) send_kp(20 + i, 30, 5, 1'b0);
    end_frame();
    cyc();
    start_frame();
    chk("t6 err_overlap", 64'(eo), 64'd3);
    out_ready = 1'b1;
    wait_idle("t6 drain");
    chk("t6 u0 trailer", 64'(trl_w[0]), 64'd5);
    chk("t6 u1 trailer", 64'(trl_w[1]), 64'd12);     // drop 1, kept 4
    for (int i = 0; i < 3; i++) begin
      send_kp(i, i, i, 1'b0);
      chk("t6 idle kp out_valid", 64'(ov), 64'd0);
    end
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
